// File: rtl/divide.sv
// Sequential 8-bit by 4-bit unsigned restoring divider with nibble-wide operand load and result readback.
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes in one edge and raises the DIVZ status bit.
module divide (
    input  logic DIV_CLK,
    input  logic RST,
    input  logic DIN0,
    input  logic DIN1,
    input  logic DIN2,
    input  logic DIN3,
    input  logic LOAD,
    input  logic SEL0,
    input  logic SEL1,
    input  logic START,
    output logic BUSY,
    output logic DONE,
    output logic R0,
    output logic R1,
    output logic R2,
    output logic R3
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dividend_q, dividend_d;
    logic [3:0]  divisor_q, divisor_d;
    logic [7:0]  quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        divz_q, divz_d;

    logic [3:0]  din;
    logic [1:0]  sel;
    logic [4:0]  trial;
    logic [4:0]  diff;
    logic        fits;
    logic        zero_div;
    logic [3:0]  rd;

    assign din   = {DIN3, DIN2, DIN1, DIN0};
    assign sel   = {SEL1, SEL0};
    assign trial = {rem_q, quo_q[7]};
    assign diff  = trial - {1'b0, divisor_q};
    assign fits  = (trial >= {1'b0, divisor_q});

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = (divisor_q == 4'd0);
`else
    assign zero_div = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        divz_d     = divz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (LOAD) begin
                    // A write always returns to IDLE, which also clears DONE.
                    state_d = S_IDLE;
                    case (sel)
                        2'b00:   dividend_d[3:0] = din;
                        2'b01:   dividend_d[7:4] = din;
                        2'b10:   divisor_d       = din;
                        default: ;
                    endcase
                end else if (START) begin
                    if (zero_div) begin
                        state_d = S_DONE;
                        quo_d   = 8'hFF;
                        rem_d   = dividend_q[3:0];
                        divz_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        quo_d   = dividend_q;
                        rem_d   = 4'd0;
                        cnt_d   = 3'd7;
                        divz_d  = 1'b0;
                    end
                end
            end

            S_RUN: begin
                // Partial remainder stays below the divisor, so 4 bits hold it between steps.
                rem_d = fits ? diff[3:0] : trial[3:0];
                quo_d = {quo_q[6:0], fits};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge DIV_CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            dividend_q <= 8'd0;
            divisor_q  <= 4'd0;
            quo_q      <= 8'd0;
            rem_q      <= 4'd0;
            cnt_q      <= 3'd0;
            divz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            divz_q     <= divz_d;
        end
    end

    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);

    always_comb begin
        rd = 4'd0;
        case (sel)
            2'b00:   rd = quo_q[3:0];
            2'b01:   rd = quo_q[7:4];
            2'b10:   rd = rem_q;
            default: rd = {1'b0, divz_q, DONE, BUSY};
        endcase
    end

    assign {R3, R2, R1, R0} = rd;

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: expected results come from plain integer division of the modelled operands.
// Build with or without DIV_ZERO_DETECT_EN; the expectations follow the same macro.
module tb_divide;

    logic DIV_CLK = 1'b0;
    logic RST, LOAD, START, SEL0, SEL1;
    logic DIN0, DIN1, DIN2, DIN3;
    logic BUSY, DONE, R0, R1, R2, R3;

    divide dut (
        .DIV_CLK(DIV_CLK), .RST(RST),
        .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
        .LOAD(LOAD), .SEL0(SEL0), .SEL1(SEL1), .START(START),
        .BUSY(BUSY), .DONE(DONE),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3)
    );

    always #5 DIV_CLK = ~DIV_CLK;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic [3:0] st;
        int         edges;
        int         busy;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] m_dd;
    logic [3:0] m_dv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] dd, input logic [3:0] dv);
        res_t e;
        bit   z;
        z = (dv == 4'd0);
        if (z) begin
            e.q = 8'hFF;
            e.r = dd[3:0];
        end else begin
            e.q = dd / {4'd0, dv};
            e.r = 4'(dd % {4'd0, dv});
        end
        e.st    = {1'b0, (DET && z), 1'b1, 1'b0};
        e.edges = (DET && z) ? 0 : 8;
        e.busy  = (DET && z) ? 0 : 8;
        return e;
    endfunction

    task automatic tick();
        @(negedge DIV_CLK);
    endtask

    task automatic set_din(input logic [3:0] nib);
        {DIN3, DIN2, DIN1, DIN0} = nib;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {SEL1, SEL0} = s;
    endtask

    task automatic read_sel(input logic [1:0] s, output logic [3:0] v);
        set_sel(s);
        #1;
        v = {R3, R2, R1, R0};
    endtask

    task automatic do_load(input logic [1:0] s, input logic [3:0] nib);
        set_sel(s);
        set_din(nib);
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        case (s)
            2'b00:   m_dd[3:0] = nib;
            2'b01:   m_dd[7:4] = nib;
            2'b10:   m_dv      = nib;
            default: ;
        endcase
    endtask

    task automatic load_ops(input logic [7:0] dd, input logic [3:0] dv);
        do_load(2'b00, dd[3:0]);
        do_load(2'b01, dd[7:4]);
        do_load(2'b10, dv);
    endtask

    // Start a division, optionally hammer START/LOAD while busy, then capture the results.
    task automatic run_div(input bit noise);
        res_t       o;
        int         n;
        int         b;
        logic [3:0] v;
        exp_q.push_back(model(m_dd, m_dv));
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        b = 0;
        while (!DONE && n < 20) begin
            if (BUSY) b++;
            if (noise && BUSY) begin
                START = 1'b1;
                LOAD  = 1'b1;
                set_sel(2'b01);
                set_din(4'hF);
            end
            tick();
            START = 1'b0;
            LOAD  = 1'b0;
            n++;
        end
        o.edges = n;
        o.busy  = b;
        read_sel(2'b00, v); o.q[3:0] = v;
        read_sel(2'b01, v); o.q[7:4] = v;
        read_sel(2'b10, v); o.r      = v;
        read_sel(2'b11, v); o.st     = v;
        obs_q.push_back(o);
    endtask

    always @(negedge DIV_CLK) begin
        res_t e;
        res_t o;
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("quotient",   32'(o.q),  32'(e.q));
            check("remainder",  32'(o.r),  32'(e.r));
            check("status",     32'(o.st), 32'(e.st));
            check("done_edges", 32'(o.edges), 32'(e.edges));
            check("busy_count", 32'(o.busy),  32'(e.busy));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        logic [7:0] dd;
        logic [3:0] dv;
        RST = 1'b1; LOAD = 1'b0; START = 1'b0;
        set_sel(2'b00);
        set_din(4'h0);
        m_dd = 8'd0;
        m_dv = 4'd0;
        tick();
        tick();
        RST = 1'b0;

        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            check($sformatf("reset_read_sel%0d", s), 32'(v), 32'd0);
        end

        // LOAD and START together from IDLE: write wins, no division starts.
        set_sel(2'b00);
        set_din(4'h5);
        LOAD  = 1'b1;
        START = 1'b1;
        tick();
        LOAD  = 1'b0;
        START = 1'b0;
        m_dd[3:0] = 4'h5;
        check("ldst_busy", 32'(BUSY), 32'd0);
        check("ldst_done", 32'(DONE), 32'd0);
        tick();
        check("ldst_busy_later", 32'(BUSY), 32'd0);
        read_sel(2'b11, v);
        check("ldst_status", 32'(v), 32'd0);

        load_ops(8'hC8, 4'd7);  run_div(1'b0);
        load_ops(8'hFF, 4'd1);  run_div(1'b0);
        load_ops(8'h05, 4'd9);  run_div(1'b0);
        run_div(1'b0);
        load_ops(8'hA7, 4'd0);  run_div(1'b0);

        // A write while DONE drops back to IDLE.
        do_load(2'b10, 4'd3);
        check("load_in_done_done", 32'(DONE), 32'd0);
        check("load_in_done_busy", 32'(BUSY), 32'd0);

        load_ops(8'hC8, 4'd7);  run_div(1'b1);

        // Reset in the middle of a run.
        load_ops(8'h64, 4'd3);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_dd = 8'd0;
        m_dv = 4'd0;
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        check("rst_mid_done", 32'(DONE), 32'd0);
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            check($sformatf("rst_mid_read_sel%0d", s), 32'(v), 32'd0);
        end
        run_div(1'b0);
        load_ops(8'h64, 4'd3);  run_div(1'b0);

        for (int i = 0; i < 30; i++) begin
            if (($urandom % 4) != 0) begin
                dd = 8'($urandom);
                dv = 4'($urandom);
                load_ops(dd, dv);
            end
            run_div(1'($urandom % 2));
        end

        tick();
        tick();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("obs_queue_drained", 32'(obs_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
